// File: rtl/check_result_arbiter.sv
// Round-robin arbiter that funnels pass/fail results from NUM_REQ checkers
// onto one registered valid/ready channel and keeps saturating tallies.
module check_result_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] pass_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic               out_pass,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eff_req;
    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    next_ptr;
    logic               handshake;
    logic               do_grant;

    // The checker granted this cycle still shows its stale req; mask it.
    assign eff_req   = req & ~gnt;
    assign any_req   = |eff_req;
    assign handshake = (state == SEND) && out_ready;
    assign do_grant  = any_req && ((state == IDLE) || handshake);
    assign next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign busy      = (state == SEND);

    // Lowest set bit overall covers the wrapped region; lowest set bit at or
    // above rr_ptr, when present, overrides it.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eff_req[i]) winner = ID_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eff_req[i] && (i >= int'(rr_ptr))) winner = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_pass  <= 1'b0;
            rr_ptr    <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            // NOTE: the default makes gnt a single-cycle pulse; the grant branch below overrides it.
            gnt <= '0;

            if (clr_cnt) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else if (handshake) begin
                if (out_pass && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
                if (!out_pass && (fail_cnt != '1)) fail_cnt <= fail_cnt + 1'b1;
            end

            if (do_grant) begin
                gnt       <= NUM_REQ'(1) << winner;
                out_id    <= winner;
                out_pass  <= pass_in[winner];
                rr_ptr    <= next_ptr;
                out_valid <= 1'b1;
                state     <= SEND;
            end else if (handshake) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: doc/check_result_arbiter.md
Name: check_result_arbiter

Overview:
- Shares one result-reporting channel among NUM_REQ independent property checkers.
- Each checker raises a request carrying a pass/fail bit. The block grants requesters round-robin and presents one registered result at a time on a valid/ready output.
- It keeps saturating pass and fail tallies.
- It sits between the checker instances and the single logging/display sink in the verification-support area of the design.

Parameters:
- NUM_REQ, 4, number of requesting checkers (2..16).
- CNT_W, 8, width of pass_cnt and fail_cnt.
- ID_W, $clog2(NUM_REQ), width of out_id (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-checker request; held high with stable pass_in until granted.
- pass_in  in  NUM_REQ  per-checker result bit; 1=pass, 0=fail; valid while req[i]=1.
- gnt  out  NUM_REQ  one-hot grant, single-cycle pulse.
- out_valid  out  1  result available on out_id/out_pass.
- out_ready  in  1  sink accepts the result when out_valid && out_ready at posedge.
- out_id  out  ID_W  index of the granted checker.
- out_pass  out  1  captured pass_in of the granted checker.
- clr_cnt  in  1  synchronous clear of both counters.
- pass_cnt  out  CNT_W  accepted passing results, saturating.
- fail_cnt  out  CNT_W  accepted failing results, saturating.
- busy  out  1  high while state==SEND.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, gnt=0, out_valid=0, out_id=0, out_pass=0, pass_cnt=0, fail_cnt=0, rr_ptr=0, busy=0.
- Reset mid-SEND discards the pending result; no counter update.
- FSM has two states, IDLE and SEND.
- IDLE, at a posedge where any effective request is set:
  - Select the winner, the first set bit scanning from rr_ptr upward with wrap NUM_REQ-1 -> 0.
  - Register out_id=winner, out_pass=pass_in[winner], gnt=onehot(winner), out_valid=1, rr_ptr=(winner+1) mod NUM_REQ.
  - Go to SEND.
  - Latency: req seen at edge T gives gnt/out_valid high in cycle T..T+1, i.e. one cycle.
- IDLE with no request: hold; gnt=0.
- gnt is high for exactly the first cycle of each SEND entry, then 0.
- SEND with out_ready=0: hold out_valid, out_id and out_pass stable; gnt=0.
- SEND with out_ready=1 (handshake at this edge):
  - Update the counters.
  - Re-arbitrate in the same edge. If an effective request exists, issue a new grant and stay in SEND (back-to-back, one result per cycle). Otherwise out_valid=0 and go to IDLE.
- Effective request = req & ~gnt. The requester whose gnt is high in the current cycle is masked, so its stale req is never double-granted.
- Requester contract: drop req (or present a new result) at the edge after gnt is seen.
- Counters on handshake: out_pass=1 increments pass_cnt, out_pass=0 increments fail_cnt. Each saturates at 2^CNT_W-1 with no wrap.
- clr_cnt=1 zeroes both counters. If it coincides with a handshake, clear wins and that result is not counted.
- clr_cnt does not affect the FSM, the grant or rr_ptr.
- Requests that arrive while in SEND wait. No request is dropped while req is held.

Test Plan:
- Single request: req=4'b0100, pass_in[2]=1, out_ready=1. Expect gnt=4'b0100 for 1 cycle, out_id=2, out_pass=1, one handshake, pass_cnt=1, then IDLE, busy=0.
- Round-robin fairness: req=4'b1111 held continuously with out_ready=1. Grants go 0,1,2,3,0 on consecutive cycles; no requester is granted twice within 4 grants.
- Backpressure: grant id 1 with pass_in=0 and out_ready=0 for 5 cycles. out_valid stays high, out_id=1 and out_pass=0 stay stable, gnt pulses once. On ready, fail_cnt=1.
- Saturation: CNT_W=3, 9 passing results accepted. pass_cnt stops at 7.
- Clear collision: clr_cnt=1 on the same edge as a handshake. pass_cnt=0 and fail_cnt=0 afterwards.
- Async reset mid-SEND: rst_n low between edges. Outputs go to 0 immediately; after release, req=4'b0010 is granted with out_id=1.
